// File: rtl/cnn_defs.sv
// Shared definitions for the CNN accelerator: FSM state type, default
// parameters, and the functions that derive accumulator and output sizes.
package cnn_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        POOL = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int DEF_IFMAP_HEIGHT  = 8;
    localparam int DEF_IFMAP_WIDTH   = 8;
    localparam int DEF_IN_CHANNELS   = 3;
    localparam int DEF_KERNEL_HEIGHT = 3;
    localparam int DEF_KERNEL_WIDTH  = 3;
    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_H_STRIDE      = 1;
    localparam int DEF_V_STRIDE      = 1;
    localparam int DEF_PADDING       = 0;

    // Product width plus sign bit plus growth for summing every tap of a window.
    function automatic int acc_width(input int data_width, input int taps);
        return 2 * data_width + 1 + $clog2(taps);
    endfunction

    function automatic int conv_dim(input int in_dim, input int k, input int pad, input int stride);
        return (in_dim - k + 2 * pad) / stride + 1;
    endfunction

    function automatic int pool_dim(input int conv);
        return conv / 2;
    endfunction

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/relu_sat.sv
// Clamp a signed accumulator into an unsigned pixel.
//   i_acc     : signed accumulator, ACC_WIDTH bits
//   i_relu_en : ReLU enable
//   o_data    : unsigned result in [0, 2^DATA_WIDTH-1]
module relu_sat #(
    parameter int ACC_WIDTH  = 21,
    parameter int DATA_WIDTH = 8
) (
    input  logic signed [ACC_WIDTH-1:0]  i_acc,
    input  logic                         i_relu_en,
    output logic        [DATA_WIDTH-1:0] o_data
);

    logic w_neg;
    logic w_over;

    always_comb begin
        w_neg  = i_acc[ACC_WIDTH-1];
        w_over = !w_neg && (|i_acc[ACC_WIDTH-2:DATA_WIDTH]);
        o_data = i_acc[DATA_WIDTH-1:0];
        // ReLU and the unsigned floor both send negatives to zero.
        if (w_neg && i_relu_en) begin
            o_data = '0;
        end else if (w_neg) begin
            o_data = '0;
        end else if (w_over) begin
            o_data = '1;
        end
    end

endmodule

// File: rtl/cnn_accelerator_mc.sv
// Multi-channel convolution engine: one MAC per cycle over a full ifmap,
// optional ReLU/saturation, optional 2x2 stride-2 max-pool done in place.
//   clk, reset   : clock, async active-low reset
//   start        : job request, accepted only in IDLE
//   pool_en      : enable max-pool (latched on acceptance)
//   relu_en      : enable ReLU (latched on acceptance)
//   ifmap_in     : unsigned pixels [ch][y][x]
//   weights      : signed kernel [ch][ky][kx]
//   bias         : signed bias, ACC_WIDTH bits
//   out_feature  : unsigned result [CONV_H][CONV_W]
//   busy, done   : job in flight / one-cycle completion pulse
module cnn_accelerator_mc
    import cnn_defs::*;
#(
    parameter int IFMAP_HEIGHT  = DEF_IFMAP_HEIGHT,
    parameter int IFMAP_WIDTH   = DEF_IFMAP_WIDTH,
    parameter int IN_CHANNELS   = DEF_IN_CHANNELS,
    parameter int KERNEL_HEIGHT = DEF_KERNEL_HEIGHT,
    parameter int KERNEL_WIDTH  = DEF_KERNEL_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int H_STRIDE      = DEF_H_STRIDE,
    parameter int V_STRIDE      = DEF_V_STRIDE,
    parameter int PADDING       = DEF_PADDING
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   pool_en,
    input  logic                   relu_en,
    input  logic [DATA_WIDTH-1:0]  ifmap_in [IN_CHANNELS][IFMAP_HEIGHT][IFMAP_WIDTH],
    input  logic signed [DATA_WIDTH-1:0] weights [IN_CHANNELS][KERNEL_HEIGHT][KERNEL_WIDTH],
    input  logic signed [acc_width(DATA_WIDTH, IN_CHANNELS*KERNEL_HEIGHT*KERNEL_WIDTH)-1:0] bias,
    output logic [DATA_WIDTH-1:0]  out_feature
        [conv_dim(IFMAP_HEIGHT, KERNEL_HEIGHT, PADDING, V_STRIDE)]
        [conv_dim(IFMAP_WIDTH, KERNEL_WIDTH, PADDING, H_STRIDE)],
    output logic                   busy,
    output logic                   done
);

    localparam int TAPS      = IN_CHANNELS * KERNEL_HEIGHT * KERNEL_WIDTH;
    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, TAPS);
    localparam int CONV_H    = conv_dim(IFMAP_HEIGHT, KERNEL_HEIGHT, PADDING, V_STRIDE);
    localparam int CONV_W    = conv_dim(IFMAP_WIDTH, KERNEL_WIDTH, PADDING, H_STRIDE);
    localparam int POOL_H    = pool_dim(CONV_H);
    localparam int POOL_W    = pool_dim(CONV_W);
    localparam bit POOL_OK   = (POOL_H > 0) && (POOL_W > 0);

    localparam int KX_W = cnt_width(KERNEL_WIDTH);
    localparam int KY_W = cnt_width(KERNEL_HEIGHT);
    localparam int CH_W = cnt_width(IN_CHANNELS);
    localparam int OX_W = cnt_width(CONV_W);
    localparam int OY_W = cnt_width(CONV_H);
    localparam int PX_W = cnt_width(POOL_W);
    localparam int PY_W = cnt_width(POOL_H);
    localparam int IX_W = cnt_width(IFMAP_WIDTH);
    localparam int IY_W = cnt_width(IFMAP_HEIGHT);

    state_e r_state;
    state_e w_state_next;

    logic [KX_W-1:0] r_kx;
    logic [KY_W-1:0] r_ky;
    logic [CH_W-1:0] r_ch;
    logic [OX_W-1:0] r_ox;
    logic [OY_W-1:0] r_oy;
    logic [PX_W-1:0] r_px;
    logic [PY_W-1:0] r_py;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic r_pool_en;
    logic r_relu_en;
    logic [DATA_WIDTH-1:0] r_out [CONV_H][CONV_W];

    logic w_last_kx, w_last_ky, w_last_ch, w_last_ox, w_last_oy;
    logic w_first_tap, w_last_tap, w_last_mac, w_last_pool;
    int   w_iy, w_ix;
    logic w_tap_valid;
    logic [DATA_WIDTH-1:0] w_pixel;
    logic signed [DATA_WIDTH-1:0] w_wgt;
    logic signed [ACC_WIDTH-1:0] w_pix_ext, w_wgt_ext, w_prod, w_acc_next;
    logic [DATA_WIDTH-1:0] w_conv_pix;
    logic [OY_W-1:0] w_r0, w_r1;
    logic [OX_W-1:0] w_c0, w_c1;
    logic [DATA_WIDTH-1:0] w_max_top, w_max_bot, w_pool_max;

    // Loop-position flags for the kx -> ky -> ch -> ox -> oy nest.
    always_comb begin
        w_last_kx   = (r_kx == KX_W'(KERNEL_WIDTH - 1));
        w_last_ky   = (r_ky == KY_W'(KERNEL_HEIGHT - 1));
        w_last_ch   = (r_ch == CH_W'(IN_CHANNELS - 1));
        w_last_ox   = (r_ox == OX_W'(CONV_W - 1));
        w_last_oy   = (r_oy == OY_W'(CONV_H - 1));
        w_first_tap = (r_kx == '0) && (r_ky == '0) && (r_ch == '0);
        w_last_tap  = w_last_kx && w_last_ky && w_last_ch;
        w_last_mac  = w_last_tap && w_last_ox && w_last_oy;
        w_last_pool = (r_px == PX_W'(POOL_W - 1)) && (r_py == PY_W'(POOL_H - 1));
    end

    // Tap fetch; coordinates falling in the padding border read as zero.
    always_comb begin
        w_iy        = int'(r_oy) * V_STRIDE + int'(r_ky) - PADDING;
        w_ix        = int'(r_ox) * H_STRIDE + int'(r_kx) - PADDING;
        w_tap_valid = (w_iy >= 0) && (w_iy < IFMAP_HEIGHT) && (w_ix >= 0) && (w_ix < IFMAP_WIDTH);
        w_pixel     = '0;
        if (w_tap_valid) begin
            w_pixel = ifmap_in[r_ch][IY_W'(w_iy)][IX_W'(w_ix)];
        end
        w_wgt      = weights[r_ch][r_ky][r_kx];
        w_pix_ext  = {{(ACC_WIDTH - DATA_WIDTH){1'b0}}, w_pixel};
        w_wgt_ext  = {{(ACC_WIDTH - DATA_WIDTH){w_wgt[DATA_WIDTH-1]}}, w_wgt};
        w_prod     = w_pix_ext * w_wgt_ext;
        // First tap of each output pixel starts from the bias, not the old sum.
        w_acc_next = (w_first_tap ? bias : r_acc) + w_prod;
    end

    relu_sat #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_relu_sat (
        .i_acc     (w_acc_next),
        .i_relu_en (r_relu_en),
        .o_data    (w_conv_pix)
    );

    // 2x2 block max. Pooling in place is safe: row-major writes never land
    // on a block that has not been read yet.
    always_comb begin
        w_r0       = OY_W'(2 * int'(r_py));
        w_r1       = w_r0 + 1'b1;
        w_c0       = OX_W'(2 * int'(r_px));
        w_c1       = w_c0 + 1'b1;
        w_max_top  = (r_out[w_r0][w_c0] > r_out[w_r0][w_c1]) ? r_out[w_r0][w_c0]
                                                             : r_out[w_r0][w_c1];
        w_max_bot  = (r_out[w_r1][w_c0] > r_out[w_r1][w_c1]) ? r_out[w_r1][w_c0]
                                                             : r_out[w_r1][w_c1];
        w_pool_max = (w_max_top > w_max_bot) ? w_max_top : w_max_bot;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: if (start) w_state_next = CONV;
            CONV: if (w_last_mac) w_state_next = (r_pool_en && POOL_OK) ? POOL : DONE;
            POOL: if (w_last_pool) w_state_next = DONE;
            DONE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);
    assign out_feature = r_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_kx      <= '0;
            r_ky      <= '0;
            r_ch      <= '0;
            r_ox      <= '0;
            r_oy      <= '0;
            r_px      <= '0;
            r_py      <= '0;
            r_acc     <= '0;
            r_pool_en <= 1'b0;
            r_relu_en <= 1'b0;
            for (int y = 0; y < CONV_H; y++) begin
                for (int x = 0; x < CONV_W; x++) begin
                    r_out[y][x] <= '0;
                end
            end
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_kx      <= '0;
                        r_ky      <= '0;
                        r_ch      <= '0;
                        r_ox      <= '0;
                        r_oy      <= '0;
                        r_px      <= '0;
                        r_py      <= '0;
                        r_acc     <= '0;
                        r_pool_en <= pool_en;
                        r_relu_en <= relu_en;
                        for (int y = 0; y < CONV_H; y++) begin
                            for (int x = 0; x < CONV_W; x++) begin
                                r_out[y][x] <= '0;
                            end
                        end
                    end
                end
                CONV: begin
                    r_acc <= w_acc_next;
                    if (w_last_tap) begin
                        r_out[r_oy][r_ox] <= w_conv_pix;
                    end
                    if (!w_last_kx) begin
                        r_kx <= r_kx + 1'b1;
                    end else begin
                        r_kx <= '0;
                        if (!w_last_ky) begin
                            r_ky <= r_ky + 1'b1;
                        end else begin
                            r_ky <= '0;
                            if (!w_last_ch) begin
                                r_ch <= r_ch + 1'b1;
                            end else begin
                                r_ch <= '0;
                                if (!w_last_ox) begin
                                    r_ox <= r_ox + 1'b1;
                                end else begin
                                    r_ox <= '0;
                                    r_oy <= w_last_oy ? '0 : r_oy + 1'b1;
                                end
                            end
                        end
                    end
                end
                POOL: begin
                    // Clear everything outside the pooled window on the final step.
                    if (w_last_pool) begin
                        for (int y = 0; y < CONV_H; y++) begin
                            for (int x = 0; x < CONV_W; x++) begin
                                if (y >= POOL_H || x >= POOL_W) begin
                                    r_out[y][x] <= '0;
                                end
                            end
                        end
                    end
                    r_out[OY_W'(r_py)][OX_W'(r_px)] <= w_pool_max;
                    if (r_px == PX_W'(POOL_W - 1)) begin
                        r_px <= '0;
                        r_py <= (r_py == PY_W'(POOL_H - 1)) ? '0 : r_py + 1'b1;
                    end else begin
                        r_px <= r_px + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cnn_accelerator_mc.md
CNN_ACCELERATOR_MC -- requirements
Module: cnn_accelerator_mc

Interface
REQ-001 SHALL have parameter IFMAP_HEIGHT, default 8, input rows per channel.
REQ-002 SHALL have parameter IFMAP_WIDTH, default 8, input columns per channel.
REQ-003 SHALL have parameter IN_CHANNELS, default 3, input channel count (>=1).
REQ-004 SHALL have parameter KERNEL_HEIGHT, default 3, and parameter KERNEL_WIDTH, default 3.
REQ-005 SHALL have parameter DATA_WIDTH, default 8, pixel/weight/output width.
REQ-006 SHALL have parameter H_STRIDE, default 1, and parameter V_STRIDE, default 1.
REQ-007 SHALL have parameter PADDING, default 0, zero-pad border width.
REQ-008 SHALL have port clk, input, 1 bit, single clock; all state on rising edge.
REQ-009 SHALL have port reset, input, 1 bit, asynchronous, active-low reset.
REQ-010 SHALL have port start, input, 1 bit, job request pulse.
REQ-011 SHALL have port pool_en, input, 1 bit, enables 2x2/stride-2 max-pool; sampled at start acceptance.
REQ-012 SHALL have port relu_en, input, 1 bit, enables ReLU; sampled at start acceptance.
REQ-013 SHALL have port ifmap_in, input, [IN_CHANNELS][IFMAP_HEIGHT][IFMAP_WIDTH] x DATA_WIDTH, unsigned pixels.
REQ-014 SHALL have port weights, input, [IN_CHANNELS][KERNEL_HEIGHT][KERNEL_WIDTH] x DATA_WIDTH, signed.
REQ-015 SHALL have port bias, input, ACC_WIDTH bits, signed.
REQ-016 SHALL have port out_feature, output, [CONV_H][CONV_W] x DATA_WIDTH, unsigned result array.
REQ-017 SHALL have port busy, output, 1 bit, high from start acceptance until done.
REQ-018 SHALL have port done, output, 1 bit, one-cycle completion pulse.

Function
REQ-019 CONV_H = (IFMAP_HEIGHT-KERNEL_HEIGHT+2*PADDING)/V_STRIDE+1 and CONV_W likewise with H_STRIDE; POOL_H = CONV_H/2, POOL_W = CONV_W/2 (floor).
REQ-020 ACC_WIDTH = 2*DATA_WIDTH+1+$clog2(IN_CHANNELS*KERNEL_HEIGHT*KERNEL_WIDTH); all MACs are signed at ACC_WIDTH, pixels zero-extended.
REQ-021 FSM states IDLE, CONV, POOL, DONE; IDLE->CONV on start; CONV->POOL after last conv pixel if pool_en latched, else CONV->DONE; POOL->DONE after last pooled pixel; DONE->IDLE unconditionally.
REQ-022 start SHALL be accepted only in IDLE; start while busy is ignored with no side effect.
REQ-023 On acceptance, out_feature SHALL be cleared to zero and pool_en/relu_en latched.
REQ-024 CONV SHALL perform exactly one MAC per cycle, iterating kx fastest, then ky, then channel, then ox, then oy; accumulator preloaded with bias per pixel.
REQ-025 Window taps outside the ifmap (padding) SHALL contribute zero.
REQ-026 On a pixel's final MAC cycle the result SHALL be written to out_feature[oy][ox] after ReLU (if enabled, negative->0) and saturation to [0, 2^DATA_WIDTH-1] (negative->0 when ReLU disabled).
REQ-027 POOL SHALL take one cycle per pooled pixel, writing max of the 2x2 block at [2py..2py+1][2px..2px+1] to out_feature[py][px], row-major; odd trailing row/column discarded; entries outside [POOL_H][POOL_W] SHALL be zeroed.
REQ-028 done SHALL pulse in DONE, exactly CONV_H*CONV_W*IN_CHANNELS*KERNEL_HEIGHT*KERNEL_WIDTH + (pool_en ? POOL_H*POOL_W : 0) + 1 cycles after the acceptance edge; busy falls with done.
REQ-029 ifmap_in, weights and bias SHALL be held stable by the source while busy; out_feature holds until the next acceptance.
REQ-030 If POOL_H or POOL_W is zero, POOL SHALL be skipped even when pool_en is set.

Reset
REQ-031 Asserting reset low SHALL asynchronously force IDLE, busy=0, done=0, all counters/accumulator=0, out_feature all zero, including mid-job.
REQ-032 After reset deassertion, start SHALL be accepted no earlier than the first rising edge.

Structure
REQ-033 State enum, ACC_WIDTH/CONV_H/CONV_W/POOL_H/POOL_W derivation functions and default parameters SHALL reside in the shared cnn_defs package/header.
REQ-034 Saturating ReLU/clamp SHALL be a separate sub-module relu_sat (ACC_WIDTH in, DATA_WIDTH out, relu_en input).

Verification
REQ-035 8x8x1, 3x3 kernel, all pixels 1, weights 1, bias 0, pool off -> all 36 outputs 9, done at cycle 325.
REQ-036 Same, pool on -> out_feature[0..2][0..2]=9, rest 0, done at cycle 334.
REQ-037 IN_CHANNELS=3, pixels 255, weights 127 -> every output saturates to 255; weights -1, relu_en=1 -> all 0.
REQ-038 3x3x1 ifmap all 1, kernel ones, PADDING=1 -> corners 4, edges 6, centre 9.
REQ-039 start re-pulsed while busy -> ignored, done timing unchanged; reset low mid-CONV -> busy=0, outputs 0 immediately, next start runs cleanly.
REQ-040 bias=-5, pixels 1, weights 1, relu_en=0 -> outputs 4; bias=-20 -> outputs 0.
